// File: rtl/gray_bin_dec_if.sv
// Handshake and result bundle for the registered Gray-to-binary decoder.
// The master side feeds codes and consumes results; the slave side is the decoder.
interface gray_bin_dec_if #(
    parameter int unsigned W   = 4,
    parameter int unsigned ECW = 8
) ();
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   g;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   b;
    logic           step_up;
    logic           step_dn;
    logic           step_rep;
    logic           step_err;
    logic [ECW-1:0] err_cnt;

    modport master (
        output in_valid, g, out_ready,
        input  in_ready, out_valid, b, step_up, step_dn, step_rep, step_err, err_cnt
    );

    modport slave (
        input  in_valid, g, out_ready,
        output in_ready, out_valid, b, step_up, step_dn, step_rep, step_err, err_cnt
    );
endinterface

// File: rtl/gray_bin_dec.sv
// Registered Gray-to-binary decoder with a single-entry output stage, a step-direction
// classifier against the previously accepted code, and a saturating adjacency-error counter.
module gray_bin_dec #(
    parameter int unsigned W   = 4,
    parameter int unsigned ECW = 8
) (
    input logic         clk,
    input logic         rst_n,
    gray_bin_dec_if.slave bus
);
    localparam logic [W-1:0]   OneW = W'(1);
    localparam logic [ECW-1:0] OneE = ECW'(1);

    // Bit i of the binary value is the XOR of Gray bits i..W-1.
    function automatic logic [W-1:0] gray2bin(input logic [W-1:0] code);
        logic [W-1:0] res;
        res = '0;
        for (int i = 0; i < W; i++) begin
            res[i] = ^(code >> i);
        end
        return res;
    endfunction

    logic           out_valid_q, out_valid_d;
    logic [W-1:0]   b_q, b_d;
    logic           step_up_q, step_up_d;
    logic           step_dn_q, step_dn_d;
    logic           step_rep_q, step_rep_d;
    logic           step_err_q, step_err_d;
    logic [ECW-1:0] err_cnt_q, err_cnt_d;
    logic [W-1:0]   prev_g_q, prev_g_d;
    logic           has_prev_q, has_prev_d;

    logic           in_ready;
    logic           accept;
    logic           xfer;
    logic [W-1:0]   bin_new;
    logic [W-1:0]   bin_prev;
    logic [W-1:0]   bin_inc;
    logic [W-1:0]   diff;
    logic           one_bit;

    assign in_ready = !out_valid_q || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;
    assign xfer     = out_valid_q && bus.out_ready;

    assign bin_new  = gray2bin(bus.g);
    assign bin_prev = gray2bin(prev_g_q);
    assign bin_inc  = bin_prev + OneW;
    assign diff     = bus.g ^ prev_g_q;
    // Nonzero with no second set bit: exactly one bit flipped.
    assign one_bit  = (diff != '0) && ((diff & (diff - OneW)) == '0);

    always_comb begin
        out_valid_d = out_valid_q;
        b_d         = b_q;
        step_up_d   = step_up_q;
        step_dn_d   = step_dn_q;
        step_rep_d  = step_rep_q;
        step_err_d  = step_err_q;
        err_cnt_d   = err_cnt_q;
        prev_g_d    = prev_g_q;
        has_prev_d  = has_prev_q;

        if (accept) begin
            out_valid_d = 1'b1;
            b_d         = bin_new;
            prev_g_d    = bus.g;
            has_prev_d  = 1'b1;
            step_up_d   = 1'b0;
            step_dn_d   = 1'b0;
            step_rep_d  = 1'b0;
            step_err_d  = 1'b0;
            if (has_prev_q) begin
                if (diff == '0) begin
                    step_rep_d = 1'b1;
                end else if (one_bit) begin
                    step_up_d = (bin_new == bin_inc);
                    step_dn_d = (bin_new != bin_inc);
                end else begin
                    step_err_d = 1'b1;
                    if (err_cnt_q != '1) begin
                        err_cnt_d = err_cnt_q + OneE;
                    end
                end
            end
        end else if (xfer) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            b_q         <= '0;
            step_up_q   <= 1'b0;
            step_dn_q   <= 1'b0;
            step_rep_q  <= 1'b0;
            step_err_q  <= 1'b0;
            err_cnt_q   <= '0;
            prev_g_q    <= '0;
            has_prev_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            b_q         <= b_d;
            step_up_q   <= step_up_d;
            step_dn_q   <= step_dn_d;
            step_rep_q  <= step_rep_d;
            step_err_q  <= step_err_d;
            err_cnt_q   <= err_cnt_d;
            prev_g_q    <= prev_g_d;
            has_prev_q  <= has_prev_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.b         = b_q;
    assign bus.step_up   = step_up_q;
    assign bus.step_dn   = step_dn_q;
    assign bus.step_rep  = step_rep_q;
    assign bus.step_err  = step_err_q;
    assign bus.err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_gray_bin_dec.sv
// Directed bench for gray_bin_dec (W=4, ECW=2): each task drives one scenario and checks
// the registered result one cycle after acceptance against hand-computed values.
module tb_gray_bin_dec;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    gray_bin_dec_if #(.W(4), .ECW(2)) bus ();

    gray_bin_dec #(.W(4), .ECW(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // {out_valid, b[3:0], up, dn, rep, err, err_cnt[1:0]}
    function automatic logic [10:0] snap();
        return {bus.out_valid, bus.b, bus.step_up, bus.step_dn, bus.step_rep, bus.step_err,
                bus.err_cnt};
    endfunction

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic send(input logic [3:0] code);
        bus.in_valid = 1'b1;
        bus.g        = code;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset;
        logic [10:0] got;
        do_reset(2);
        got = snap();
        n_checks++;
        if (got !== 11'b0_0000_0000_00)
            $display("FAIL reset_state got=%b want=%b", got, 11'b0_0000_0000_00);
        else n_pass++;
        n_checks++;
        if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b want=1", bus.in_ready);
        else n_pass++;
        send(4'b0110);
        got = snap();
        n_checks++;
        if (got !== 11'b1_0100_0000_00)
            $display("FAIL first_decode got=%b want=%b", got, 11'b1_0100_0000_00);
        else n_pass++;
    endtask

    task automatic test_up_sweep;
        logic [10:0] got, exp;
        logic [3:0]  code;
        do_reset(1);
        for (int i = 0; i < 16; i++) begin
            code = 4'(i) ^ (4'(i) >> 1);
            send(code);
            got = snap();
            exp = {1'b1, 4'(i), (i != 0), 3'b000, 2'b00};
            n_checks++;
            if (got !== exp) $display("FAIL up_sweep[%0d] got=%b want=%b", i, got, exp);
            else n_pass++;
        end
        send(4'b0000);
        got = snap();
        n_checks++;
        if (got !== 11'b1_0000_1000_00)
            $display("FAIL up_wrap got=%b want=%b", got, 11'b1_0000_1000_00);
        else n_pass++;
    endtask

    task automatic test_down_repeat;
        logic [3:0]  codes [4] = '{4'b0111, 4'b0101, 4'b0111, 4'b0111};
        logic [10:0] exps  [4] = '{11'b1_0101_0000_00, 11'b1_0110_1000_00,
                                   11'b1_0101_0100_00, 11'b1_0101_0010_00};
        logic [10:0] got;
        do_reset(1);
        for (int i = 0; i < 4; i++) begin
            send(codes[i]);
            got = snap();
            n_checks++;
            if (got !== exps[i]) $display("FAIL down_rep[%0d] got=%b want=%b", i, got, exps[i]);
            else n_pass++;
        end
        // 0 -> 15 is a legal single step down.
        do_reset(1);
        send(4'b0000);
        send(4'b1000);
        got = snap();
        n_checks++;
        if (got !== 11'b1_1111_0100_00)
            $display("FAIL down_wrap got=%b want=%b", got, 11'b1_1111_0100_00);
        else n_pass++;
    endtask

    task automatic test_err_sat;
        logic [3:0]  codes [5] = '{4'b0000, 4'b0011, 4'b0101, 4'b1010, 4'b0001};
        logic [10:0] exps  [5] = '{11'b1_0000_0000_00, 11'b1_0010_0001_01,
                                   11'b1_0110_0001_10, 11'b1_1100_0001_11,
                                   11'b1_0001_0001_11};
        logic [10:0] got;
        do_reset(1);
        for (int i = 0; i < 5; i++) begin
            send(codes[i]);
            got = snap();
            n_checks++;
            if (got !== exps[i]) $display("FAIL err_sat[%0d] got=%b want=%b", i, got, exps[i]);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure;
        logic [10:0] got;
        do_reset(1);
        bus.out_ready = 1'b0;
        send(4'b0001);
        bus.in_valid = 1'b1;
        bus.g        = 4'b0011;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (bus.in_ready !== 1'b0) $display("FAIL bp_ready[%0d] got=%b want=0", i, bus.in_ready);
            else n_pass++;
            got = snap();
            n_checks++;
            if (got !== 11'b1_0001_0000_00)
                $display("FAIL bp_hold[%0d] got=%b want=%b", i, got, 11'b1_0001_0000_00);
            else n_pass++;
            @(posedge clk);
        end
        #1;
        bus.out_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) $display("FAIL bp_release_ready got=%b want=1", bus.in_ready);
        else n_pass++;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        got = snap();
        n_checks++;
        if (got !== 11'b1_0010_1000_00)
            $display("FAIL bp_release got=%b want=%b", got, 11'b1_0010_1000_00);
        else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0) $display("FAIL bp_no_dup got=%b want=0", bus.out_valid);
        else n_pass++;
    endtask

    task automatic test_reset_midstream;
        logic [10:0] got;
        do_reset(1);
        send(4'b0000);
        send(4'b0110);
        n_checks++;
        if (bus.err_cnt !== 2'd1) $display("FAIL mid_pre_err got=%0d want=1", bus.err_cnt);
        else n_pass++;
        do_reset(1);
        n_checks++;
        if ({bus.out_valid, bus.err_cnt} !== 3'b000)
            $display("FAIL mid_reset got=%b want=000", {bus.out_valid, bus.err_cnt});
        else n_pass++;
        send(4'b1111);
        got = snap();
        n_checks++;
        if (got !== 11'b1_1010_0000_00)
            $display("FAIL mid_after got=%b want=%b", got, 11'b1_1010_0000_00);
        else n_pass++;
    endtask

    initial begin
        clk           = 1'b0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.g         = '0;
        bus.out_ready = 1'b1;
        n_checks      = 0;
        n_pass        = 0;
        test_reset();
        test_up_sweep();
        test_down_repeat();
        test_err_sat();
        test_backpressure();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
